// File: rtl/audio_frame_sequencer.sv
// audio_frame_sequencer: moves frames from sample storage through the
// processor into result storage, with overlap hop, watchdog and abort.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   go, abort                start / cancel a sequence
//   cfg_frames, cfg_hop      frame count and source hop, latched on go
//   src_rd_idx, src_data     sample storage read (same-cycle data)
//   proc_data_wr_en, proc_input_index, proc_data_in  processor fill port
//   proc_start, proc_done    processor start pulse / done level
//   proc_output_index, proc_data_out                 processor drain port
//   dst_wr_en, dst_wr_idx, dst_data                  result storage write
//   busy, all_done, error, frames_done               status
module audio_frame_sequencer #(
    parameter int BUS_W       = 512,
    parameter int WORDS       = 64,
    parameter int ADDR_W      = 16,
    parameter int FRAME_W     = 16,
    parameter int TIMEOUT_CYC = 65536,
    localparam int IDX_W      = $clog2(WORDS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               go,
    input  logic               abort,
    input  logic [FRAME_W-1:0] cfg_frames,
    input  logic [IDX_W:0]     cfg_hop,
    output logic [ADDR_W-1:0]  src_rd_idx,
    input  logic [BUS_W-1:0]   src_data,
    output logic               proc_data_wr_en,
    output logic [IDX_W-1:0]   proc_input_index,
    output logic [BUS_W-1:0]   proc_data_in,
    output logic               proc_start,
    input  logic               proc_done,
    output logic [IDX_W-1:0]   proc_output_index,
    input  logic [BUS_W-1:0]   proc_data_out,
    output logic               dst_wr_en,
    output logic [ADDR_W-1:0]  dst_wr_idx,
    output logic [BUS_W-1:0]   dst_data,
    output logic               busy,
    output logic               all_done,
    output logic               error,
    output logic [FRAME_W-1:0] frames_done
);

    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [IDX_W-1:0] W_LAST = IDX_W'(WORDS - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FILL, S_START, S_WAIT, S_DRAIN, S_ERR
    } state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   w_q;
    logic [WD_W-1:0]    wd_q;
    logic [ADDR_W-1:0]  src_base_q, dst_base_q, hop_q;
    logic [FRAME_W-1:0] frames_q, frames_done_q;
    logic               done_q;
    logic               wr_en_q, start_q, dst_wr_en_q;
    logic               busy_q, all_done_q, error_q;
    logic [IDX_W-1:0]   in_idx_q;
    logic [BUS_W-1:0]   data_in_q, dst_data_q;
    logic [ADDR_W-1:0]  dst_idx_q;

    logic [IDX_W-1:0]   w_d;
    logic [WD_W-1:0]    wd_d;
    logic [FRAME_W-1:0] frames_done_d;
    logic [ADDR_W-1:0]  hop_d;

    assign w_d           = w_q + IDX_W'(1);
    assign wd_d          = wd_q + WD_W'(1);
    assign frames_done_d = frames_done_q + FRAME_W'(1);

    // Zero or oversized hop means non-overlapping frames.
    always_comb begin
        hop_d = ADDR_W'(WORDS);
        if (cfg_hop != '0 && int'(cfg_hop) <= WORDS)
            hop_d = ADDR_W'(cfg_hop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            w_q           <= '0;
            wd_q          <= '0;
            src_base_q    <= '0;
            dst_base_q    <= '0;
            hop_q         <= '0;
            frames_q      <= '0;
            frames_done_q <= '0;
            done_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            start_q       <= 1'b0;
            dst_wr_en_q   <= 1'b0;
            busy_q        <= 1'b0;
            all_done_q    <= 1'b0;
            error_q       <= 1'b0;
            in_idx_q      <= '0;
            data_in_q     <= '0;
            dst_data_q    <= '0;
            dst_idx_q     <= '0;
        end else begin
            done_q      <= proc_done;
            wr_en_q     <= 1'b0;
            start_q     <= 1'b0;
            dst_wr_en_q <= 1'b0;
            all_done_q  <= 1'b0;
            if (abort) begin
                // Dropping the strobes above also discards the pending write.
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_ERR: begin
                        busy_q <= 1'b0;
                        if (go) begin
                            frames_q      <= cfg_frames;
                            hop_q         <= hop_d;
                            src_base_q    <= '0;
                            dst_base_q    <= '0;
                            frames_done_q <= '0;
                            error_q       <= 1'b0;
                            w_q           <= '0;
                            if (cfg_frames == '0) begin
                                all_done_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else begin
                                busy_q  <= 1'b1;
                                state_q <= S_FILL;
                            end
                        end
                    end
                    S_FILL: begin
                        wr_en_q   <= 1'b1;
                        in_idx_q  <= w_q;
                        data_in_q <= src_data;
                        if (w_q == W_LAST) begin
                            w_q     <= '0;
                            state_q <= S_START;
                        end else begin
                            w_q <= w_d;
                        end
                    end
                    S_START: begin
                        start_q <= 1'b1;
                        wd_q    <= '0;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        // A done edge in the expiry cycle still drains.
                        if (proc_done && !done_q) begin
                            w_q     <= '0;
                            state_q <= S_DRAIN;
                        end else if (wd_q == WD_LAST) begin
                            error_q <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_ERR;
                        end else begin
                            wd_q <= wd_d;
                        end
                    end
                    S_DRAIN: begin
                        dst_wr_en_q <= 1'b1;
                        dst_idx_q   <= dst_base_q + ADDR_W'(w_q);
                        dst_data_q  <= proc_data_out;
                        if (w_q == W_LAST) begin
                            w_q           <= '0;
                            frames_done_q <= frames_done_d;
                            src_base_q    <= src_base_q + hop_q;
                            dst_base_q    <= dst_base_q + ADDR_W'(WORDS);
                            // Busy stays up through the all_done cycle.
                            if (frames_done_d == frames_q) begin
                                all_done_q <= 1'b1;
                                state_q    <= S_IDLE;
                            end else begin
                                state_q <= S_FILL;
                            end
                        end else begin
                            w_q <= w_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign src_rd_idx        = (state_q == S_FILL) ?
                               src_base_q + ADDR_W'(w_q) : '0;
    assign proc_output_index = (state_q == S_DRAIN) ? w_q : '0;
    assign proc_data_wr_en   = wr_en_q;
    assign proc_input_index  = in_idx_q;
    assign proc_data_in      = data_in_q;
    assign proc_start        = start_q;
    assign dst_wr_en         = dst_wr_en_q;
    assign dst_wr_idx        = dst_idx_q;
    assign dst_data          = dst_data_q;
    assign busy              = busy_q;
    assign all_done          = all_done_q;
    assign error             = error_q;
    assign frames_done       = frames_done_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// tb_audio_frame_sequencer: directed bench with storage, echo processor
// and done-delay models around a small audio_frame_sequencer instance.
module tb_audio_frame_sequencer;

    localparam int BUS_W = 32;
    localparam int WORDS = 8;
    localparam int ADDR_W = 8;
    localparam int FRAME_W = 8;
    localparam int TO = 20;
    localparam int DLY = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               go = 1'b0;
    logic               abort = 1'b0;
    logic [FRAME_W-1:0] cfg_frames = '0;
    logic [3:0]         cfg_hop = '0;
    logic [ADDR_W-1:0]  src_rd_idx;
    logic [BUS_W-1:0]   src_data;
    logic               proc_data_wr_en;
    logic [2:0]         proc_input_index;
    logic [BUS_W-1:0]   proc_data_in;
    logic               proc_start;
    logic               proc_done = 1'b0;
    logic [2:0]         proc_output_index;
    logic [BUS_W-1:0]   proc_data_out;
    logic               dst_wr_en;
    logic [ADDR_W-1:0]  dst_wr_idx;
    logic [BUS_W-1:0]   dst_data;
    logic               busy, all_done, error;
    logic [FRAME_W-1:0] frames_done;

    audio_frame_sequencer #(
        .BUS_W(BUS_W), .WORDS(WORDS), .ADDR_W(ADDR_W),
        .FRAME_W(FRAME_W), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort),
        .cfg_frames(cfg_frames), .cfg_hop(cfg_hop),
        .src_rd_idx(src_rd_idx), .src_data(src_data),
        .proc_data_wr_en(proc_data_wr_en),
        .proc_input_index(proc_input_index),
        .proc_data_in(proc_data_in), .proc_start(proc_start),
        .proc_done(proc_done), .proc_output_index(proc_output_index),
        .proc_data_out(proc_data_out), .dst_wr_en(dst_wr_en),
        .dst_wr_idx(dst_wr_idx), .dst_data(dst_data), .busy(busy),
        .all_done(all_done), .error(error), .frames_done(frames_done)
    );

    always #5 clk = ~clk;

    assign src_data = {8'h5A, 16'h0000, src_rd_idx};

    logic [BUS_W-1:0] pmem [WORDS];
    always @(posedge clk)
        if (proc_data_wr_en) pmem[proc_input_index] <= proc_data_in;
    assign proc_data_out = pmem[proc_output_index];

    // 0: done rises DLY cycles after start, 1: never, 2: stuck high
    int done_mode = 0;
    int dcnt = 0;
    always @(posedge clk) begin
        if (done_mode == 2) begin
            proc_done <= 1'b1;
        end else if (proc_start) begin
            proc_done <= 1'b0;
            dcnt <= DLY;
        end else if (dcnt > 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1 && done_mode == 0) proc_done <= 1'b1;
        end
    end

    int n_chk = 0;
    int n_fail = 0;
    int hop_e = WORDS;
    int wr_cnt = 0, dst_cnt = 0, st_cnt = 0, ad_cnt = 0;
    int wr_base = 0, dst_base = 0, st0 = 0, ad0 = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] sidx(input int k);
        return 8'(((k / WORDS) * hop_e + (k % WORDS)) % 256);
    endfunction

    task automatic monitor();
        int k;
        forever begin
            @(negedge clk);
            if (proc_data_wr_en) begin
                k = wr_cnt - wr_base;
                check("wr_idx", 64'(proc_input_index), 64'(k % WORDS));
                check("wr_data", 64'(proc_data_in),
                      64'({8'h5A, 16'h0000, sidx(k)}));
                wr_cnt++;
            end
            if (dst_wr_en) begin
                k = dst_cnt - dst_base;
                check("dst_idx", 64'(dst_wr_idx), 64'(k % 256));
                check("dst_data", 64'(dst_data),
                      64'({8'h5A, 16'h0000, sidx(k)}));
                dst_cnt++;
            end
            if (proc_start) begin
                check("start_nowr", 64'(proc_data_wr_en), 64'(0));
                st_cnt++;
            end
            if (all_done) ad_cnt++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input int frames, input int hop);
        hop_e = (hop == 0 || hop > WORDS) ? WORDS : hop;
        wr_base = wr_cnt;
        dst_base = dst_cnt;
        st0 = st_cnt;
        ad0 = ad_cnt;
        cfg_frames = FRAME_W'(frames);
        cfg_hop = 4'(hop);
        go = 1'b1;
        tick();
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (all_done) begin
                seen = 1;
                break;
            end
        end
    endtask

    task automatic run_full(input string tag, input int frames,
                            input int hop);
        bit seen;
        start_seq(frames, hop);
        wait_done(40 * frames + 100, seen);
        check({tag, "_seen"}, 64'(seen), 64'(1));
        check({tag, "_adwr"}, 64'(dst_wr_en), 64'(1));
        check({tag, "_busy"}, 64'(busy), 64'(1));
        check({tag, "_frames"}, 64'(frames_done), 64'(frames));
        check({tag, "_starts"}, 64'(st_cnt - st0), 64'(frames));
        check({tag, "_wrs"}, 64'(wr_cnt - wr_base), 64'(frames * WORDS));
        tick();
        check({tag, "_dsts"}, 64'(dst_cnt - dst_base), 64'(frames * WORDS));
        check({tag, "_idle"}, 64'(busy), 64'(0));
        check({tag, "_ad1"}, 64'(ad_cnt - ad0), 64'(1));
    endtask

    initial begin
        int n;
        bit seen;
        fork
            monitor();
        join_none

        tick();
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_err", 64'(error), 64'(0));
        check("rst_ad", 64'(all_done), 64'(0));
        check("rst_fd", 64'(frames_done), 64'(0));
        check("rst_st", 64'(proc_start), 64'(0));
        check("rst_wr", 64'(proc_data_wr_en), 64'(0));
        check("rst_dwr", 64'(dst_wr_en), 64'(0));
        check("rst_src", 64'(src_rd_idx), 64'(0));
        check("rst_didx", 64'(dst_wr_idx), 64'(0));
        rst = 1'b0;
        tick();

        run_full("seq2", 2, 0);
        run_full("hop4", 3, 4);
        run_full("hopsat", 2, 15);

        done_mode = 1;
        start_seq(1, 0);
        n = 0;
        while (!proc_start && n < 50) begin tick(); n++; end
        check("to_start", 64'(proc_start), 64'(1));
        n = 0;
        while (!error && n < 200) begin tick(); n++; end
        check("to_cycles", 64'(n), 64'(TO));
        check("to_err", 64'(error), 64'(1));
        check("to_busy", 64'(busy), 64'(0));
        check("to_dst", 64'(dst_cnt - dst_base), 64'(0));
        done_mode = 0;
        start_seq(1, 0);
        check("to_clr", 64'(error), 64'(0));
        check("to_rbusy", 64'(busy), 64'(1));
        wait_done(200, seen);
        check("to_rdone", 64'(seen), 64'(1));
        tick();

        start_seq(2, 0);
        n = 0;
        while (frames_done != 1 && n < 200) begin tick(); n++; end
        check("ab_fd1", 64'(frames_done), 64'(1));
        tick(); tick(); tick();
        abort = 1'b1;
        go = 1'b1;
        tick();
        abort = 1'b0;
        go = 1'b0;
        check("ab_busy", 64'(busy), 64'(0));
        check("ab_wr", 64'(proc_data_wr_en), 64'(0));
        check("ab_src", 64'(src_rd_idx), 64'(0));
        tick(); tick();
        check("ab_wr2", 64'(proc_data_wr_en), 64'(0));
        check("ab_fdh", 64'(frames_done), 64'(1));
        check("ab_st", 64'(st_cnt - st0), 64'(1));
        check("ab_ad", 64'(ad_cnt - ad0), 64'(0));
        check("ab_wrn", 64'(wr_cnt - wr_base), 64'(11));
        run_full("ab_re", 1, 0);

        start_seq(0, 0);
        check("z_ad", 64'(all_done), 64'(1));
        check("z_dwr", 64'(dst_wr_en), 64'(0));
        check("z_busy", 64'(busy), 64'(0));
        tick();
        check("z_ad0", 64'(all_done), 64'(0));
        check("z_wrs", 64'(wr_cnt - wr_base), 64'(0));

        start_seq(1, 0);
        tick(); tick(); tick();
        cfg_frames = 8'd5;
        go = 1'b1;
        tick();
        go = 1'b0;
        wait_done(200, seen);
        check("gb_seen", 64'(seen), 64'(1));
        check("gb_fd", 64'(frames_done), 64'(1));
        check("gb_wrs", 64'(wr_cnt - wr_base), 64'(WORDS));
        tick();

        done_mode = 2;
        tick(); tick();
        start_seq(1, 0);
        n = 0;
        while (!error && n < 200) begin tick(); n++; end
        check("hi_err", 64'(error), 64'(1));
        check("hi_dst", 64'(dst_cnt - dst_base), 64'(0));
        done_mode = 0;

        start_seq(1, 0);
        n = 0;
        while (!dst_wr_en && n < 200) begin tick(); n++; end
        check("rd_dwr", 64'(dst_wr_en), 64'(1));
        tick();
        rst = 1'b1;
        tick();
        check("rr_dwr", 64'(dst_wr_en), 64'(0));
        check("rr_busy", 64'(busy), 64'(0));
        check("rr_fd", 64'(frames_done), 64'(0));
        check("rr_oidx", 64'(proc_output_index), 64'(0));
        check("rr_didx", 64'(dst_wr_idx), 64'(0));
        check("rr_ddat", 64'(dst_data), 64'(0));
        rst = 1'b0;
        tick();

        run_full("wrap", 37, 7);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
